shift_rotate_pipe: RTL
======================

# shift_rotate_pipe

Parametrised, pipelined barrel shifter/rotator for the datapath ALU. It performs logical left/right shift, arithmetic right shift, rotate left and rotate right on a WIDTH-bit operand. Shift amounts of WIDTH or more have defined results. It produces carry and zero flags, passes a tag through unchanged, and uses a valid/ready handshake so the ALU issue logic can stream one operation per cycle with backpressure.

## Interface
Parameters:
- WIDTH, 32: operand width; power of two, at least 8.
- AMT_W, 32: shift-amount port width; at least $clog2(WIDTH)+1.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- clear_n  in  1  synchronous, active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the unit accepts the operation this cycle.
- in_op  in  3  operation code (shift_pkg::op_e).
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  unsigned shift/rotate amount.
- in_tag  in  TAG_W  tag, returned unchanged.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  result.
- out_carry  out  1  carry flag (defined under Operation).
- out_zero  out  1  high when out_data is 0.
- out_err  out  1  high when the op code was illegal.
- out_tag  out  TAG_W  tag of this result.

## Operation
Op codes:
- 0 SHL
- 1 SHR (logical)
- 2 ASR
- 3 ROL
- 4 ROR
- 5–7 illegal: out_data = in_data, out_carry = 0, out_err = 1.

Amount rules (A = in_amt, unsigned, full AMT_W bits considered):
- SHL, SHR with A ≥ WIDTH: data = 0.
- ASR with A ≥ WIDTH: every bit = in_data[WIDTH-1].
- ROL, ROR: the effective amount is A mod WIDTH; a rotate by 0 returns in_data.
- A = 0 for any shift: data unchanged, carry = 0.

Carry:
- SHL: the last bit shifted out, in_data[WIDTH-A] for 1 ≤ A ≤ WIDTH; 0 for A > WIDTH.
- SHR: in_data[A-1] for 1 ≤ A ≤ WIDTH; 0 for A > WIDTH.
- ASR: in_data[A-1] for 1 ≤ A ≤ WIDTH; the sign bit for A > WIDTH.
- ROL: result[0].
- ROR: result[WIDTH-1].

Datapath:
- Logarithmic structure with S = $clog2(WIDTH) stages. Stage k conditionally shifts or rotates by 2^k.
- Out-of-range detection (any A bit at or above bit S set, for shifts) and carry pre-selection are resolved in stage 0.
- op, tag and flags travel with the data. Every stage has a valid bit and a registered payload.

Handshake:
- A transfer occurs when valid && ready, on either side.
- stall = out_valid && !out_ready. stall freezes every stage register and every valid bit.
- in_ready = !stall && clear_n.
- No bubble collapsing: a stall halts the whole pipe.
- Results leave in acceptance order. No operation is dropped or duplicated.
- out_data, out_carry, out_zero, out_err and out_tag are held stable while out_valid && !out_ready.

## Timing
- Latency: exactly S cycles from acceptance to out_valid when unstalled; 5 cycles at WIDTH = 32.
- Throughput: 1 operation per cycle.
- Reset: while clear_n is sampled low, all valid bits clear and every output is 0: out_valid, out_data, out_carry, out_zero, out_err, out_tag. in_ready is 0.
- Reset mid-operation: in-flight operations are discarded. The first in_valid after clear_n returns high is accepted on that cycle.
- Simultaneous events: a stall releasing and a new input arriving in the same cycle is legal. The pipe advances and the new input enters stage 0.
- out_zero and out_carry are registered with out_data; there is no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready only.

## Structure
- shift_pkg:
  - op_e enum (OP_SHL … OP_ROR).
  - OP_W = 3.
  - A function returning the legal/illegal status of an op.
- Sub-module shift_stage:
  - Parameters WIDTH, TAG_W, STEP.
  - Performs one conditional 2^STEP shift/rotate plus its pipeline register and enable.
  - Instantiated S times by a generate loop in shift_rotate_pipe.

## Test plan
(WIDTH=32, AMT_W=32)
- SHL 0x0000_0001 by 4, tag 3 → out_data 0x0000_0010, carry 0, zero 0, tag 3, out_valid exactly 5 cycles after acceptance.
- ASR 0x8000_0000 by 40 → 0xFFFF_FFFF, carry 1. SHR 0x8000_0000 by 32 → 0x0000_0000, carry 1, zero 1.
- ROR 0x0000_00F1 by 36 → 0x1000_000F, carry 0. ROL 0xDEAD_BEEF by 32 → 0xDEAD_BEEF, carry 1.
- Backpressure: 8 back-to-back random ops with out_ready low for cycles 3–6:
  - all 8 results arrive, in order, bit-exact against the reference model;
  - in_ready is low exactly while stalled;
  - outputs are held during the stall.
- clear_n low for 1 cycle with 4 ops in flight → out_valid 0 the next cycle, no stale results ever emerge, and a new op completes 5 cycles after acceptance.
- Op 6 with data 0x1234_5678 → out_data 0x1234_5678, out_err 1, carry 0; the neighbouring legal ops are unaffected.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes and helpers shared by the shift/rotate pipeline
package shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SHL = 3'd0,
        OP_SHR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    // Codes above OP_ROR are reserved and pass the operand through with err set.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/shift_rotate_pipe_if.sv
// rtl/shift_rotate_pipe_if.sv - operation/result handshake bundle for shift_rotate_pipe
interface shift_rotate_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32,
    parameter int TAG_W = 4
) ();
    import shift_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_data, in_amt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_data, in_amt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
    );

endinterface

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one conditional 2^STEP shift/rotate step plus its pipeline register
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int STEP  = 0
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [OP_W-1:0]          in_op,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_carry,
    input  logic                     in_err,
    output logic                     valid_q,
    output logic [OP_W-1:0]          op_q,
    output logic [$clog2(WIDTH)-1:0] amt_q,
    output logic [WIDTH-1:0]         data_q,
    output logic [TAG_W-1:0]         tag_q,
    output logic                     carry_q,
    output logic                     zero_q,
    output logic                     err_q
);

    localparam int S  = $clog2(WIDTH);
    localparam int SH = 1 << STEP;

    logic             valid_d;
    logic [OP_W-1:0]  op_d;
    logic [S-1:0]     amt_d;
    logic [WIDTH-1:0] data_d;
    logic [TAG_W-1:0] tag_d;
    logic             carry_d;
    logic             zero_d;
    logic             err_d;

    always_comb begin
        valid_d = in_valid;
        op_d    = in_op;
        amt_d   = in_amt;
        tag_d   = in_tag;
        err_d   = in_err;
        data_d  = in_data;
        if (in_amt[STEP]) begin
            case (in_op)
                OP_SHL:  data_d = in_data << SH;
                OP_SHR:  data_d = in_data >> SH;
                OP_ASR:  data_d = $signed(in_data) >>> SH;
                OP_ROL:  data_d = (in_data << SH) | (in_data >> (WIDTH - SH));
                OP_ROR:  data_d = (in_data >> SH) | (in_data << (WIDTH - SH));
                default: data_d = in_data;
            endcase
        end
        // Rotate carry tracks the partial result, so the last stage leaves the final bit.
        carry_d = in_carry;
        if (in_op == OP_ROL) begin
            carry_d = data_d[0];
        end else if (in_op == OP_ROR) begin
            carry_d = data_d[WIDTH-1];
        end
        zero_d = (data_d == '0);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            amt_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/shift_rotate_pipe.sv
// rtl/shift_rotate_pipe.sv - pipelined barrel shifter/rotator with carry/zero flags and valid/ready flow
module shift_rotate_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32,
    parameter int TAG_W = 4
) (
    input  logic               clock,
    input  logic               clear_n,
    shift_rotate_pipe_if.slave bus
);

    localparam int S = $clog2(WIDTH);
    localparam logic [S-1:0] IDX_ONE = S'(1);

    logic             stall;
    logic             adv;

    logic [S-1:0]     amt_low;
    logic [S-1:0]     shl_idx;
    logic [S-1:0]     shr_idx;
    logic             amt_zero;
    logic             amt_oor;
    logic             amt_is_w;
    logic             amt_over;
    logic             op_legal;
    logic             op_shift;
    logic             sign;
    logic [WIDTH-1:0] s0_data;
    logic [S-1:0]     s0_amt;
    logic             s0_carry;
    logic             s0_err;

    logic             st_valid [0:S];
    logic [OP_W-1:0]  st_op    [0:S];
    logic [S-1:0]     st_amt   [0:S];
    logic [WIDTH-1:0] st_data  [0:S];
    logic [TAG_W-1:0] st_tag   [0:S];
    logic             st_carry [0:S];
    logic             st_err   [0:S];
    logic [S:1]       st_zero;
    logic             unused_bits;

    assign stall        = st_valid[S] && !bus.out_ready;
    assign adv          = !stall;
    assign bus.in_ready = !stall && clear_n;

    // Out-of-range shifts collapse to their fill value here and run the remaining stages
    // with a zero amount; the shifted-out carry bit is picked straight from the operand.
    always_comb begin
        amt_low  = bus.in_amt[S-1:0];
        amt_oor  = |(bus.in_amt >> S);
        amt_zero = (bus.in_amt == '0);
        amt_is_w = (bus.in_amt == AMT_W'(WIDTH));
        amt_over = amt_oor && !amt_is_w;
        shl_idx  = '0 - amt_low;
        shr_idx  = amt_low - IDX_ONE;
        sign     = bus.in_data[WIDTH-1];
        op_legal = op_is_legal(bus.in_op);
        op_shift = op_legal && (bus.in_op <= OP_ASR);

        s0_data  = bus.in_data;
        s0_amt   = amt_low;
        s0_carry = 1'b0;
        s0_err   = !op_legal;
        if (!op_legal) begin
            s0_amt = '0;
        end else if (op_shift) begin
            if (amt_oor) begin
                s0_amt  = '0;
                s0_data = (bus.in_op == OP_ASR) ? {WIDTH{sign}} : '0;
            end
            if (amt_zero) begin
                s0_carry = 1'b0;
            end else if (amt_over) begin
                s0_carry = (bus.in_op == OP_ASR) && sign;
            end else if (bus.in_op == OP_SHL) begin
                s0_carry = bus.in_data[shl_idx];
            end else begin
                s0_carry = bus.in_data[shr_idx];
            end
        end
    end

    assign st_valid[0] = bus.in_valid && bus.in_ready;
    assign st_op[0]    = bus.in_op;
    assign st_amt[0]   = s0_amt;
    assign st_data[0]  = s0_data;
    assign st_tag[0]   = bus.in_tag;
    assign st_carry[0] = s0_carry;
    assign st_err[0]   = s0_err;

    for (genvar k = 0; k < S; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .STEP  (k)
        ) u_stage (
            .clock    (clock),
            .clear_n  (clear_n),
            .en       (adv),
            .in_valid (st_valid[k]),
            .in_op    (st_op[k]),
            .in_amt   (st_amt[k]),
            .in_data  (st_data[k]),
            .in_tag   (st_tag[k]),
            .in_carry (st_carry[k]),
            .in_err   (st_err[k]),
            .valid_q  (st_valid[k+1]),
            .op_q     (st_op[k+1]),
            .amt_q    (st_amt[k+1]),
            .data_q   (st_data[k+1]),
            .tag_q    (st_tag[k+1]),
            .carry_q  (st_carry[k+1]),
            .zero_q   (st_zero[k+1]),
            .err_q    (st_err[k+1])
        );
    end

    assign bus.out_valid = st_valid[S];
    assign bus.out_data  = st_data[S];
    assign bus.out_carry = st_carry[S];
    assign bus.out_zero  = st_zero[S];
    assign bus.out_err   = st_err[S];
    assign bus.out_tag   = st_tag[S];

    // Only the final stage's zero flag is observable; op and amount stop at the output.
    assign unused_bits = ^{st_op[S], st_amt[S], st_zero[S-1:1]};

endmodule
